sort_frame_reader: RTL and testbench
====================================

SORT_FRAME_READER -- requirements
Module: sort_frame_reader

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits.
REQ-002 Parameter FRAME_LEN, default 8, samples per sorted frame; power of two, >= 2.
REQ-003 Parameter ASCEND, default 1; 1 = frames are expected non-decreasing, 0 = non-increasing.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 in_data  in  DATA_W  sorted sample from the sorter output.
REQ-007 in_valid  in  1  in_data valid this cycle; no backpressure, every valid cycle is one sample.
REQ-008 clr  in  1  synchronous clear of the sticky overflow flag.
REQ-009 out_data  out  DATA_W  replayed sample.
REQ-010 out_valid / out_ready  out / in  1 / 1  downstream handshake; a beat transfers when both are high.
REQ-011 out_last  out  1  high on the final beat of a frame.
REQ-012 frame_min / frame_max / frame_med  out  DATA_W each  statistics of the last completed frame.
REQ-013 stats_valid  out  1  one-cycle pulse when the frame_* outputs update.
REQ-014 frame_err  out  1  order violation in the last completed frame; valid with stats_valid, held until the next update.
REQ-015 overflow  out  1  sticky flag: a frame was dropped.

Function
REQ-016 Input samples are grouped into frames of FRAME_LEN consecutive in_valid beats, counted by wr_cnt, which wraps FRAME_LEN-1 -> 0.
REQ-017 Storage is two banks (ping-pong) of FRAME_LEN x DATA_W; each bank state is FREE, FILL or FULL.
REQ-018 At the first sample of a frame, the lowest-index FREE bank becomes FILL; if no bank is FREE, the whole frame is discarded (still counted), and overflow sets on that first sample.
REQ-019 Order check: for ASCEND=1, in_data < previous sample (index >= 1) flags the frame; for ASCEND=0, in_data > previous sample flags it.
REQ-020 On the last sample of a stored frame, the bank becomes FULL. In the next cycle stats_valid pulses with frame_min, frame_max, frame_med and frame_err.
REQ-021 For ASCEND=1, frame_min = sample 0, frame_max = sample FRAME_LEN-1, frame_med = sample FRAME_LEN/2-1 (lower median). For ASCEND=0, min and max swap and frame_med is unchanged.
REQ-022 Statistics are computed even for a frame with frame_err set; discarded frames produce no stats_valid.
REQ-023 Read FSM states:
  - IDLE: if a bank is FULL, go to SEND with the oldest FULL bank and rd_cnt = 0.
  - SEND: out_valid = 1, out_data = bank[rd_cnt]. On a transfer rd_cnt increments. On the transfer with rd_cnt = FRAME_LEN-1 (out_last = 1) the bank becomes FREE; the FSM goes to SEND on the other bank if it is FULL, else to IDLE.
REQ-024 Read latency: out_valid rises the cycle after stats_valid at the earliest (2 cycles after the last input sample).
REQ-025 out_data, out_last and the bank index are stable while out_valid = 1 and out_ready = 0.
REQ-026 A bank freed by a transfer is not usable by a frame whose first sample arrives in the same cycle; that frame is discarded.
REQ-027 Banks are serviced strictly in fill order; no frame is reordered or replayed twice.
REQ-028 Overflow clears only on clr or reset. If clr and a new overflow event occur in the same cycle, overflow stays set.

Reset
REQ-029 rst_n = 0 sets: both banks FREE, wr_cnt and rd_cnt = 0, FSM = IDLE, and out_valid, out_last, stats_valid, frame_err, overflow = 0. frame_min, frame_max, frame_med and out_data = 0.
REQ-030 Reset mid-frame or mid-transfer abandons all buffered data; the first in_valid after reset release is sample 0 of a new frame.
REQ-031 Bank memory contents are not reset.

Structure
REQ-032 A shared package sort_pkg holds DATA_W/FRAME_LEN defaults, the bank-state enum (FREE, FILL, FULL) and the read-FSM state enum (IDLE, SEND).
REQ-033 One sub-module, sort_bank_ram: a FRAME_LEN x DATA_W register array with 1 write port and 1 asynchronous read port, instantiated twice.

Verification
REQ-034 Frame 1,3,4,5,5,6,7,7 with out_ready = 1 -> stats_valid with min 1, max 7, med 5, frame_err 0; out_data is the same sequence with out_last on the 8th beat.
REQ-035 Frame 3,6,7,4,7,5,5,1 -> frame_err = 1, min 3, max 1, med 4; all 8 beats are still replayed.
REQ-036 Three back-to-back frames with out_ready = 0 -> frames 1 and 2 are buffered and frame 3 is dropped with overflow = 1; then out_ready = 1 -> frames 1 then 2 are replayed, with no stats_valid for frame 3.
REQ-037 out_ready toggling 1010... during a replay -> 8 beats in order, with out_data stable on every stalled cycle.
REQ-038 rst_n low for 1 cycle after the 4th beat of a replay -> outputs return to reset values; the next 8 samples form a correct new frame.
REQ-039 Overflow set, then clr pulsed -> overflow = 0 in the next cycle; clr concurrent with a new drop -> overflow stays 1.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the sort frame reader: parameter defaults,
// bank occupancy states and read-FSM states.
package sort_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_FRAME_LEN = 8;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } bank_st_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_st_e;

endpackage

// File: rtl/sort_frame_reader_if.sv
// Sample stream in and replay stream out of the sort frame reader.
// The reader is the slave; the sorter/sink side is the master.
interface sort_frame_reader_if
    import sort_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output out_last
    );

endinterface

// File: rtl/sort_bank_ram.sv
// One frame of sample storage: single write port, asynchronous read.
// Contents are deliberately left unreset.
module sort_bank_ram
    import sort_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(FRAME_LEN)-1:0] waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [$clog2(FRAME_LEN)-1:0] raddr,
    output logic [DATA_W-1:0]            rdata
);

    logic [DATA_W-1:0] mem_q [FRAME_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sort_frame_reader.sv
// Ping-pong frame buffer behind a sorter: checks order, reports
// min/max/median per frame and replays frames in fill order.
module sort_frame_reader
    import sort_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int ASCEND    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    sort_frame_reader_if.slave bus,
    output logic [DATA_W-1:0] frame_min,
    output logic [DATA_W-1:0] frame_max,
    output logic [DATA_W-1:0] frame_med,
    output logic              stats_valid,
    output logic              frame_err,
    output logic              overflow
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] MED_IDX  = CNT_W'(FRAME_LEN / 2 - 1);

    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] first_q, first_d;
    logic [DATA_W-1:0] med_q, med_d;
    logic              err_acc_q, err_acc_d;

    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] med_out_q, med_out_d;
    logic              stats_valid_q, stats_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              ovf_q, ovf_d;

    bank_st_e          bank_q [2];
    bank_st_e          bank_d [2];
    logic              older_q, older_d;

    rd_st_e            state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              rd_free;

    logic              first_smp;
    logic              last_smp;
    logic              no_free;
    logic              cur_bank;
    logic              cur_drop;
    logic              viol;
    logic              we;
    logic [DATA_W-1:0] rdata0, rdata1;

    always_comb begin
        first_smp = (wr_cnt_q == '0);
        last_smp  = (wr_cnt_q == LAST_IDX);
        no_free   = (bank_q[0] != FREE) && (bank_q[1] != FREE);
        cur_bank  = first_smp ? (bank_q[0] != FREE) : wr_bank_q;
        cur_drop  = first_smp ? no_free : wr_drop_q;
        viol      = (ASCEND != 0) ? (bus.in_data < prev_q)
                                  : (bus.in_data > prev_q);
        we        = bus.in_valid && !cur_drop;
    end

    sort_bank_ram #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN)
    ) u_bank0 (
        .clk  (clk),
        .we   (we && !cur_bank),
        .waddr(wr_cnt_q),
        .wdata(bus.in_data),
        .raddr(rd_cnt_q),
        .rdata(rdata0)
    );

    sort_bank_ram #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN)
    ) u_bank1 (
        .clk  (clk),
        .we   (we && cur_bank),
        .waddr(wr_cnt_q),
        .wdata(bus.in_data),
        .raddr(rd_cnt_q),
        .rdata(rdata1)
    );

    // Write side: frame counting, drop decision, stats capture.
    always_comb begin
        wr_cnt_d      = wr_cnt_q;
        wr_bank_d     = wr_bank_q;
        wr_drop_d     = wr_drop_q;
        prev_d        = prev_q;
        first_d       = first_q;
        med_d         = med_q;
        err_acc_d     = err_acc_q;
        min_d         = min_q;
        max_d         = max_q;
        med_out_d     = med_out_q;
        stats_valid_d = 1'b0;
        frame_err_d   = frame_err_q;
        ovf_d         = clr ? 1'b0 : ovf_q;

        if (bus.in_valid) begin
            wr_cnt_d = last_smp ? '0 : wr_cnt_q + CNT_W'(1);
            prev_d   = bus.in_data;
            if (first_smp) begin
                wr_bank_d = cur_bank;
                wr_drop_d = no_free;
                first_d   = bus.in_data;
                err_acc_d = 1'b0;
                if (no_free) begin
                    ovf_d = 1'b1;
                end
            end else begin
                err_acc_d = err_acc_q | viol;
            end
            if (wr_cnt_q == MED_IDX) begin
                med_d = bus.in_data;
            end
            if (last_smp && !cur_drop) begin
                stats_valid_d = 1'b1;
                frame_err_d   = err_acc_q | viol;
                min_d         = (ASCEND != 0) ? first_q : bus.in_data;
                max_d         = (ASCEND != 0) ? bus.in_data : first_q;
                med_out_d     = med_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        rd_free   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bank_q[0] == FULL &&
                    (bank_q[1] != FULL || !older_q)) begin
                    state_d   = SEND;
                    rd_bank_d = 1'b0;
                    rd_cnt_d  = '0;
                end else if (bank_q[1] == FULL) begin
                    state_d   = SEND;
                    rd_bank_d = 1'b1;
                    rd_cnt_d  = '0;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (rd_cnt_q == LAST_IDX) begin
                        rd_free  = 1'b1;
                        rd_cnt_d = '0;
                        if (bank_q[~rd_bank_q] == FULL) begin
                            rd_bank_d = ~rd_bank_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The freed bank is FULL and the filled bank is FREE/FILL, so the
    // two updates never hit the same bank.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        older_d   = older_q;
        if (rd_free) begin
            bank_d[rd_bank_q] = FREE;
        end
        if (we) begin
            if (first_smp) begin
                bank_d[cur_bank] = FILL;
            end
            if (last_smp) begin
                bank_d[cur_bank] = FULL;
                if (bank_q[~cur_bank] != FULL) begin
                    older_d = cur_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q      <= '0;
            wr_bank_q     <= 1'b0;
            wr_drop_q     <= 1'b0;
            prev_q        <= '0;
            first_q       <= '0;
            med_q         <= '0;
            err_acc_q     <= 1'b0;
            min_q         <= '0;
            max_q         <= '0;
            med_out_q     <= '0;
            stats_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            ovf_q         <= 1'b0;
            bank_q[0]     <= FREE;
            bank_q[1]     <= FREE;
            older_q       <= 1'b0;
            state_q       <= IDLE;
            rd_bank_q     <= 1'b0;
            rd_cnt_q      <= '0;
        end else begin
            wr_cnt_q      <= wr_cnt_d;
            wr_bank_q     <= wr_bank_d;
            wr_drop_q     <= wr_drop_d;
            prev_q        <= prev_d;
            first_q       <= first_d;
            med_q         <= med_d;
            err_acc_q     <= err_acc_d;
            min_q         <= min_d;
            max_q         <= max_d;
            med_out_q     <= med_out_d;
            stats_valid_q <= stats_valid_d;
            frame_err_q   <= frame_err_d;
            ovf_q         <= ovf_d;
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            older_q       <= older_d;
            state_q       <= state_d;
            rd_bank_q     <= rd_bank_d;
            rd_cnt_q      <= rd_cnt_d;
        end
    end

    always_comb begin
        bus.out_valid = (state_q == SEND);
        bus.out_last  = bus.out_valid && (rd_cnt_q == LAST_IDX);
        bus.out_data  = '0;
        if (bus.out_valid) begin
            bus.out_data = rd_bank_q ? rdata1 : rdata0;
        end
    end

    assign frame_min   = min_q;
    assign frame_max   = max_q;
    assign frame_med   = med_out_q;
    assign stats_valid = stats_valid_q;
    assign frame_err   = frame_err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_sort_frame_reader.sv
// Directed bench for sort_frame_reader (DATA_W=8, FRAME_LEN=8, ASCEND=1).
module tb_sort_frame_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] frame_min, frame_max, frame_med;
    logic       stats_valid, frame_err, overflow;

    int total = 0;
    int bad   = 0;

    logic [8:0] beat_q [$];
    int         st_cnt = 0;

    always #5 clk = ~clk;

    sort_frame_reader_if #(.DATA_W(8)) bus ();

    sort_frame_reader #(
        .DATA_W   (8),
        .FRAME_LEN(8),
        .ASCEND   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus),
        .frame_min  (frame_min),
        .frame_max  (frame_max),
        .frame_med  (frame_med),
        .stats_valid(stats_valid),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    // Log every accepted beat and every stats pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready)
                beat_q.push_back({bus.out_last, bus.out_data});
            if (stats_valid)
                st_cnt++;
        end
    end

    task automatic drive(input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 0; i < 8; i++) drive(f[63-8*i -: 8]);
    endtask

    task automatic idle_in();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1;
        bus.out_ready = r;
    endtask

    task automatic wait_beats(input int n);
        for (int c = 0; c < 60 && beat_q.size() < n; c++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 10 && !bus.out_valid; c++) @(negedge clk);
    endtask

    task automatic drain();
        set_ready(1'b1);
        for (int c = 0; c < 60 && bus.out_valid; c++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst out_last: got %b want 0", bus.out_last); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst out_data: got %h want 00", bus.out_data); end
        total++; if (stats_valid !== 1'b0) begin bad++; $display("FAIL rst stats_valid: got %b want 0", stats_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst frame_err: got %b want 0", frame_err); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst overflow: got %b want 0", overflow); end
        total++; if ({frame_min, frame_max, frame_med} !== 24'h0) begin bad++; $display("FAIL rst stats: got %h want 000000", {frame_min, frame_max, frame_med}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_frame_stats(input string name, input logic [63:0] f,
                                    input logic [7:0] emin, input logic [7:0] emax,
                                    input logic [7:0] emed, input logic eerr);
        int b0;
        int s0;
        logic [8:0] exp;
        logic [8:0] got;
        set_ready(1'b1);
        b0 = beat_q.size();
        s0 = st_cnt;
        send_frame(f);
        idle_in();
        @(negedge clk);
        total++; if (stats_valid !== 1'b1) begin bad++; $display("FAIL %s stats_valid: got %b want 1", name, stats_valid); end
        total++; if (frame_min !== emin) begin bad++; $display("FAIL %s min: got %h want %h", name, frame_min, emin); end
        total++; if (frame_max !== emax) begin bad++; $display("FAIL %s max: got %h want %h", name, frame_max, emax); end
        total++; if (frame_med !== emed) begin bad++; $display("FAIL %s med: got %h want %h", name, frame_med, emed); end
        total++; if (frame_err !== eerr) begin bad++; $display("FAIL %s err: got %b want %b", name, frame_err, eerr); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s early out_valid: got %b want 0", name, bus.out_valid); end
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL %s latency out_valid: got %b want 1", name, bus.out_valid); end
        wait_beats(b0 + 8);
        repeat (3) @(negedge clk);
        #1;
        total++; if (beat_q.size() !== b0 + 8) begin bad++; $display("FAIL %s beat count: got %0d want %0d", name, beat_q.size() - b0, 8); end
        for (int i = 0; i < 8; i++) begin
            exp = {i == 7, f[63-8*i -: 8]};
            got = (b0 + i < beat_q.size()) ? beat_q[b0+i] : 9'h1ff;
            total++; if (got !== exp) begin bad++; $display("FAIL %s beat%0d: got %h want %h", name, i, got, exp); end
        end
        total++; if (frame_err !== eerr) begin bad++; $display("FAIL %s err hold: got %b want %b", name, frame_err, eerr); end
        total++; if (st_cnt - s0 !== 1) begin bad++; $display("FAIL %s stats pulses: got %0d want 1", name, st_cnt - s0); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] fa;
        logic [63:0] fb;
        logic [63:0] fc;
        logic [8:0]  exp;
        logic [8:0]  got;
        int b0;
        int s0;
        fa = 64'h01_02_03_04_05_06_07_08;
        fb = 64'h20_21_22_23_24_25_26_27;
        fc = 64'h40_41_42_43_44_45_46_47;
        set_ready(1'b0);
        b0 = beat_q.size();
        s0 = st_cnt;
        send_frame(fa);
        send_frame(fb);
        send_frame(fc);
        idle_in();
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL b2b overflow: got %b want 1", overflow); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin bad++; $display("FAIL b2b held: got v=%b d=%h want v=1 d=01", bus.out_valid, bus.out_data); end
        repeat (2) @(negedge clk);
        #1;
        total++; if (st_cnt - s0 !== 2) begin bad++; $display("FAIL b2b stats pulses: got %0d want 2", st_cnt - s0); end
        set_ready(1'b1);
        wait_beats(b0 + 16);
        repeat (4) @(negedge clk);
        #1;
        total++; if (beat_q.size() !== b0 + 16) begin bad++; $display("FAIL b2b beat count: got %0d want 16", beat_q.size() - b0); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 8) ? {i == 7, fa[63-8*i -: 8]} : {i == 15, fb[63-8*(i-8) -: 8]};
            got = (b0 + i < beat_q.size()) ? beat_q[b0+i] : 9'h1ff;
            total++; if (got !== exp) begin bad++; $display("FAIL b2b beat%0d: got %h want %h", i, got, exp); end
        end
        total++; if (st_cnt - s0 !== 2) begin bad++; $display("FAIL b2b dropped stats: got %0d want 2", st_cnt - s0); end
    endtask

    task automatic test_stall();
        logic [63:0] fd;
        logic [8:0]  exp;
        int k;
        fd = 64'h10_12_14_16_18_1a_1c_1e;
        set_ready(1'b0);
        send_frame(fd);
        idle_in();
        wait_valid();
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready = (c % 2 == 0);
            @(negedge clk);
            exp = {k == 7, fd[63-8*k -: 8]};
            total++;
            if (bus.out_valid !== 1'b1 || {bus.out_last, bus.out_data} !== exp) begin
                bad++;
                $display("FAIL stall beat%0d: got v=%b %h want v=1 %h", k, bus.out_valid, {bus.out_last, bus.out_data}, exp);
            end
            if (bus.out_ready) k++;
        end
        total++; if (k !== 8) begin bad++; $display("FAIL stall beats: got %0d want 8", k); end
        drain();
    endtask

    task automatic test_reset_mid();
        int k;
        set_ready(1'b0);
        send_frame(64'h05_15_25_35_45_55_65_75);
        idle_in();
        wait_valid();
        set_ready(1'b1);
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) k++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 8'h00) begin bad++; $display("FAIL midrst out: got v=%b l=%b d=%h want 0 0 00", bus.out_valid, bus.out_last, bus.out_data); end
        total++; if ({frame_min, frame_max, frame_med} !== 24'h0) begin bad++; $display("FAIL midrst stats: got %h want 000000", {frame_min, frame_max, frame_med}); end
        total++; if (stats_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL midrst flags: got sv=%b err=%b want 0 0", stats_valid, frame_err); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midrst overflow: got %b want 0", overflow); end
        test_frame_stats("postrst", 64'h02_02_03_09_0a_0b_0c_0d, 8'h02, 8'h0d, 8'h09, 1'b0);
    endtask

    task automatic test_clr();
        logic [63:0] fj;
        fj = 64'h50_51_52_53_54_55_56_57;
        set_ready(1'b0);
        send_frame(64'h60_61_62_63_64_65_66_67);
        send_frame(64'h70_71_72_73_74_75_76_77);
        send_frame(64'h80_81_82_83_84_85_86_87);
        idle_in();
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr setup overflow: got %b want 1", overflow); end
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr overflow: got %b want 0", overflow); end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = fj[63:56];
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_data = fj[55:48];
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr+drop overflow: got %b want 1", overflow); end
        for (int i = 2; i < 8; i++) drive(fj[63-8*i -: 8]);
        idle_in();
        drain();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr sticky: got %b want 1", overflow); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_frame_stats("sorted", 64'h01_03_04_05_05_06_07_07, 8'h01, 8'h07, 8'h05, 1'b0);
        test_frame_stats("unsorted", 64'h03_06_07_04_07_05_05_01, 8'h03, 8'h01, 8'h04, 1'b1);
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
